// File: rtl/nw_traceback.sv
// nw_traceback: traceback engine for the Needleman-Wunsch score grid.
// It reads H[i][j] from a synchronous score memory, walks from (LENGTH,LENGTH)
// back to (0,0), and emits one alignment op per step over valid/ready.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   start              begin a traceback (ignored while busy)
//   s1, s2             row / column strings, CWIDTH bits per char, char 0 in LSBs
//   rd_en, rd_addr     score memory read strobe / address i*(LENGTH+1)+j
//   rd_data            signed H[i][j], valid one cycle after rd_en
//   op_valid, op_ready op handshake
//   op, op_last        00 match, 01 mismatch, 10 up, 11 left; op_last marks (0,0)
//   busy, done, err    status levels
//
// state  | meaning
// IDLE   | waiting for start
// RD_CUR | read H[LENGTH][LENGTH] (once per traceback)
// RD_NBR | three reads: diag, up, left of (i,j)
// DECIDE | pick the predecessor (left value taken live from rd_data)
// EMIT   | present op until accepted, then move (i,j)
// DONE   | one-cycle completion state
module nw_traceback #(
   parameter int LENGTH   = 10,
   parameter int CWIDTH   = 2,
   parameter int SWIDTH   = 16,
   parameter int MATCH    = 1,
   parameter int INDEL    = -1,
   parameter int MISMATCH = -1,
   parameter int ADDRW    = $clog2((LENGTH+1)*(LENGTH+1))
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LENGTH*CWIDTH-1:0]   s1,
   input  logic [LENGTH*CWIDTH-1:0]   s2,
   output logic                       rd_en,
   output logic [ADDRW-1:0]           rd_addr,
   input  logic signed [SWIDTH-1:0]   rd_data,
   output logic                       op_valid,
   input  logic                       op_ready,
   output logic [1:0]                 op,
   output logic                       op_last,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int IW = $clog2(LENGTH+1);
   localparam logic [IW-1:0]            LAST_IDX   = IW'(LENGTH);
   localparam logic [ADDRW-1:0]         ROW_STRIDE = ADDRW'(LENGTH+1);
   localparam logic signed [SWIDTH-1:0] W_MATCH    = SWIDTH'(MATCH);
   localparam logic signed [SWIDTH-1:0] W_MISM     = SWIDTH'(MISMATCH);
   localparam logic signed [SWIDTH-1:0] W_INDEL    = SWIDTH'(INDEL);

   localparam logic [1:0] OP_MATCH = 2'b00;
   localparam logic [1:0] OP_MISM  = 2'b01;
   localparam logic [1:0] OP_UP    = 2'b10;
   localparam logic [1:0] OP_LEFT  = 2'b11;

   typedef enum logic [2:0] {IDLE, RD_CUR, RD_NBR, DECIDE, EMIT, DONE} state_t;
   // Which captured register the read issued last cycle is destined for.
   typedef enum logic [1:0] {TAG_NONE, TAG_CUR, TAG_DIAG, TAG_UP} tag_t;

   state_t                      state, state_nxt;
   tag_t                        tag;
   logic [1:0]                  cnt;
   logic [IW-1:0]               i, j, im1, jm1;
   logic [LENGTH*CWIDTH-1:0]    s1_q, s2_q;
   logic [CWIDTH-1:0]           c1, c2;
   logic signed [SWIDTH-1:0]    cur, diag_q, up_q, nbr_q;
   logic signed [SWIDTH-1:0]    w, diag_sum, up_sum, left_sum, dec_val;
   logic [1:0]                  op_q, dec_op;
   logic                        last_q, dec_ok, dec_last;
   logic [IW-1:0]               dec_ni, dec_nj, nxt_i, nxt_j;

   function automatic logic [ADDRW-1:0] addr_of(input logic [IW-1:0] r,
                                                input logic [IW-1:0] c);
      return ADDRW'(r) * ROW_STRIDE + ADDRW'(c);
   endfunction

   // Guarded decrements keep the char part-selects in range on the boundary.
   assign im1 = (i == '0) ? '0 : i - IW'(1);
   assign jm1 = (j == '0) ? '0 : j - IW'(1);
   assign c1  = s1_q[im1*CWIDTH +: CWIDTH];
   assign c2  = s2_q[jm1*CWIDTH +: CWIDTH];

   always_comb begin
      w        = (c1 == c2) ? W_MATCH : W_MISM;
      diag_sum = diag_q + w;
      up_sum   = up_q + W_INDEL;
      left_sum = rd_data + W_INDEL;
      dec_ok   = 1'b1;
      dec_op   = OP_LEFT;
      dec_val  = cur;
      if (i == '0) begin
         dec_op = OP_LEFT;
      end else if (j == '0) begin
         dec_op = OP_UP;
      end else if (diag_sum == cur) begin
         dec_op  = (c1 == c2) ? OP_MATCH : OP_MISM;
         dec_val = diag_q;
      end else if (up_sum == cur) begin
         dec_op  = OP_UP;
         dec_val = up_q;
      end else if (left_sum == cur) begin
         dec_op  = OP_LEFT;
         dec_val = rd_data;
      end else begin
         dec_ok = 1'b0;
      end
   end

   // Every op except left decrements i; every op except up decrements j.
   assign dec_ni   = (dec_op != OP_LEFT) ? im1 : i;
   assign dec_nj   = (dec_op != OP_UP)   ? jm1 : j;
   assign dec_last = (dec_ni == '0) && (dec_nj == '0);
   assign nxt_i    = (op_q != OP_LEFT) ? im1 : i;
   assign nxt_j    = (op_q != OP_UP)   ? jm1 : j;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = '0;
      case (state)
         IDLE: if (start) state_nxt = RD_CUR;
         RD_CUR: begin
            rd_en     = 1'b1;
            rd_addr   = addr_of(i, j);
            state_nxt = RD_NBR;
         end
         RD_NBR: begin
            rd_en = 1'b1;
            case (cnt)
               2'd0:    rd_addr = addr_of(im1, jm1);
               2'd1:    rd_addr = addr_of(im1, j);
               default: rd_addr = addr_of(i, jm1);
            endcase
            if (cnt == 2'd2) state_nxt = DECIDE;
         end
         DECIDE: state_nxt = dec_ok ? EMIT : DONE;
         EMIT: begin
            if (op_ready) begin
               if (last_q)                          state_nxt = DONE;
               else if (nxt_i != '0 && nxt_j != '0) state_nxt = RD_NBR;
               else                                 state_nxt = DECIDE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag    <= TAG_NONE;
         cnt    <= '0;
         i      <= '0;
         j      <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         cur    <= '0;
         diag_q <= '0;
         up_q   <= '0;
         nbr_q  <= '0;
         op_q   <= '0;
         last_q <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         tag <= TAG_NONE;
         case (tag)
            TAG_CUR:  cur    <= rd_data;
            TAG_DIAG: diag_q <= rd_data;
            TAG_UP:   up_q   <= rd_data;
            default:  ;
         endcase
         case (state)
            IDLE: begin
               if (start) begin
                  s1_q <= s1;
                  s2_q <= s2;
                  i    <= LAST_IDX;
                  j    <= LAST_IDX;
                  busy <= 1'b1;
                  done <= 1'b0;
                  err  <= 1'b0;
               end
            end
            RD_CUR: tag <= TAG_CUR;
            RD_NBR: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'd0)      tag <= TAG_DIAG;
               else if (cnt == 2'd1) tag <= TAG_UP;
               else                  cnt <= '0;
            end
            DECIDE: begin
               if (dec_ok) begin
                  op_q   <= dec_op;
                  last_q <= dec_last;
                  nbr_q  <= dec_val;
               end else begin
                  done <= 1'b1;
                  err  <= 1'b1;
                  busy <= 1'b0;
               end
            end
            EMIT: begin
               if (op_ready) begin
                  i   <= nxt_i;
                  j   <= nxt_j;
                  cur <= nbr_q;
                  if (last_q) begin
                     done <= 1'b1;
                     busy <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign op_valid = (state == EMIT);
   assign op       = op_valid ? op_q : 2'b00;
   assign op_last  = op_valid & last_q;

endmodule

// File: tb/tb_nw_traceback.sv
module tb_nw_traceback;
   localparam int L  = 4;
   localparam int CW = 2;
   localparam int SW = 16;
   localparam int AW = 5;
   localparam int N  = (L+1)*(L+1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [L*CW-1:0]      s1 = '0, s2 = '0;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic signed [SW-1:0] rd_data = '0;
   logic                 op_valid;
   logic                 op_ready = 1'b1;
   logic [1:0]           op;
   logic                 op_last, busy, done, err;

   nw_traceback #(.LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .MATCH(1), .INDEL(-1),
                  .MISMATCH(-1), .ADDRW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .s1(s1), .s2(s2),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_last(op_last),
      .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   logic signed [SW-1:0] mem [0:N-1];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int n_cmp = 0, n_fail = 0;
   int hold_n = 0, wait_ctr = 0;
   int idx = 0, rd_cnt = 0, exp_err = 0;
   logic [1:0]    exp_op[$];
   logic [AW-1:0] exp_addr[$];

   task automatic check(input string name, input longint act, input longint expv);
      n_cmp++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic int ch(input logic [L*CW-1:0] s, input int k);
      logic [L*CW-1:0] t;
      t = s >> (k*CW);
      return int'(t[CW-1:0]);
   endfunction

   function automatic int hv(input int r, input int c);
      return int'(mem[r*(L+1)+c]);
   endfunction

   // Fill memory with the reference NW matrix built from the recurrence.
   task automatic build(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b,
                        input bit corrupt);
      int h [0:L][0:L];
      for (int r = 0; r <= L; r++) begin
         for (int c = 0; c <= L; c++) begin
            if (r == 0)      h[r][c] = -c;
            else if (c == 0) h[r][c] = -r;
            else begin
               int d, u, lf, m;
               d  = h[r-1][c-1] + ((ch(a, r-1) == ch(b, c-1)) ? 1 : -1);
               u  = h[r-1][c] - 1;
               lf = h[r][c-1] - 1;
               m  = d;
               if (u > m)  m = u;
               if (lf > m) m = lf;
               h[r][c] = m;
            end
            mem[r*(L+1)+c] = SW'(h[r][c]);
         end
      end
      if (corrupt) mem[L*(L+1)+L] = SW'(7);
   endtask

   // Walk the matrix as held in memory and list the ops and reads expected.
   task automatic model(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b);
      int r, c, cv, w;
      exp_op.delete();
      exp_addr.delete();
      exp_err = 0;
      r = L; c = L;
      cv = hv(L, L);
      exp_addr.push_back(AW'(L*(L+1)+L));
      while (!(r == 0 && c == 0)) begin
         if (r == 0) begin
            exp_op.push_back(2'b11); c--;
         end else if (c == 0) begin
            exp_op.push_back(2'b10); r--;
         end else begin
            exp_addr.push_back(AW'((r-1)*(L+1)+c-1));
            exp_addr.push_back(AW'((r-1)*(L+1)+c));
            exp_addr.push_back(AW'(r*(L+1)+c-1));
            w = (ch(a, r-1) == ch(b, c-1)) ? 1 : -1;
            if (hv(r-1, c-1) + w == cv) begin
               exp_op.push_back((w == 1) ? 2'b00 : 2'b01);
               cv = hv(r-1, c-1); r--; c--;
            end else if (hv(r-1, c) - 1 == cv) begin
               exp_op.push_back(2'b10); cv = hv(r-1, c); r--;
            end else if (hv(r, c-1) - 1 == cv) begin
               exp_op.push_back(2'b11); cv = hv(r, c-1); c--;
            end else begin
               exp_err = 1;
               break;
            end
         end
      end
   endtask

   function automatic longint pack_ops();
      longint p = 0;
      foreach (exp_op[k]) p = (p << 2) | longint'(exp_op[k]);
      return p;
   endfunction

   always @(posedge clk) begin
      #1;
      if (!op_valid) begin
         wait_ctr = 0;
         op_ready = (hold_n == 0);
      end else if (wait_ctr < hold_n) begin
         wait_ctr++;
         op_ready = 1'b0;
      end else begin
         op_ready = 1'b1;
      end
   end

   // Single compare process: reads and ops against the model, every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) begin
            if (rd_cnt >= exp_addr.size()) check("extra_rd_en", 1, 0);
            else check($sformatf("rd_addr[%0d]", rd_cnt), rd_addr, exp_addr[rd_cnt]);
            rd_cnt++;
         end
         if (op_valid) begin
            if (idx >= exp_op.size()) check("extra_op", 1, 0);
            else begin
               check($sformatf("op[%0d]", idx), op, exp_op[idx]);
               check($sformatf("op_last[%0d]", idx), op_last,
                     (idx == exp_op.size()-1 && exp_err == 0) ? 1 : 0);
               if (op_ready) idx++;
            end
         end
      end
   end

   task automatic launch(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b);
      idx = 0; rd_cnt = 0;
      @(posedge clk); #1;
      s1 = a; s2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("rd_cur_rd_en", rd_en, 1);
      check("start_busy", busy, 1);
      check("start_done_clr", done, 0);
   endtask

   task automatic run(input string nm, input logic [L*CW-1:0] a, input logic [L*CW-1:0] b,
                      input bit corrupt, input int hold, input longint lit_h44,
                      input longint lit_n, input longint lit_pack);
      build(a, b, corrupt);
      model(a, b);
      check({nm, "_lit_h44"}, hv(L, L), lit_h44);
      check({nm, "_lit_nops"}, exp_op.size(), lit_n);
      check({nm, "_lit_ops"}, pack_ops(), lit_pack);
      hold_n = hold;
      launch(a, b);
      for (int c = 0; c < 600 && !done; c++) @(negedge clk);
      check({nm, "_done"}, done, 1);
      check({nm, "_err"}, err, exp_err);
      check({nm, "_busy"}, busy, 0);
      check({nm, "_ops_accepted"}, idx, exp_op.size());
      check({nm, "_reads"}, rd_cnt, exp_addr.size());
      hold_n = 0;
      @(posedge clk); @(posedge clk);
   endtask

   localparam logic [L*CW-1:0] ACGT = 8'hE4;
   localparam logic [L*CW-1:0] AAAA = 8'h00;
   localparam logic [L*CW-1:0] CCCC = 8'h55;
   localparam logic [L*CW-1:0] CGTA = 8'h39;

   initial begin
      repeat (2) @(negedge clk);
      check("reset_outputs", {rd_en, rd_addr, op_valid, op, op_last, busy, done, err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run("match",    ACGT, ACGT, 1'b0, 0,  4, 4, 64'h00);
      run("mismatch", AAAA, CCCC, 1'b0, 0, -4, 4, 64'h55);
      run("gap",      ACGT, CGTA, 1'b0, 0,  1, 5, 64'h302);
      run("corrupt",  ACGT, ACGT, 1'b1, 0,  7, 0, 64'h00);
      run("stall",    ACGT, ACGT, 1'b0, 5,  4, 4, 64'h00);

      // Reset during the second neighbour read burst, then a clean rerun.
      build(ACGT, ACGT, 1'b0);
      model(ACGT, ACGT);
      launch(ACGT, ACGT);
      for (int c = 0; c < 200 && rd_cnt < 5; c++) begin
         @(negedge clk); #2;
      end
      check("rst_reached_rd5", rd_cnt, 5);
      rst = 1'b1;
      #1;
      check("rst_async_outputs", {rd_en, rd_addr, op_valid, op, op_last, busy, done, err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run("after_rst", ACGT, ACGT, 1'b0, 0, 4, 4, 64'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
